// File: rtl/uu_acmac_rx_buf_wr.sv
// uu_acmac_rx_buf_wr
// Receive-side frame writer in front of the single-port RX frame memory.
// It writes each incoming frame from address 0, publishes a one-frame
// descriptor (length, error), and while that descriptor is pending it lends
// the memory port to the consumer's read side.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid/sof/eof/err/data     decrypted byte stream (cannot be stalled)
//   frame_rdy/len/err             descriptor of the held frame
//   frame_ack                     consumer releases the buffer
//   rd_en, rd_addr, rd_data       consumer read port (honoured while frame_rdy)
//   drop_cnt                      saturating count of discarded frames
//   mem_rx_in_*                   registered memory port, write or read
//   mem_rx_out_data               memory read data
//
// state | meaning
// IDLE  | waiting for a start-of-frame byte
// RECV  | writing frame bytes, r_cnt = bytes written so far
// DROP  | oversize frame, discarding bytes until eof
// HOLD  | complete frame in memory, descriptor valid, consumer owns the port
module uu_acmac_rx_buf_wr #(
  parameter int MAX_LEN = 1536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        in_sof,
  input  logic        in_eof,
  input  logic        in_err,
  input  logic [7:0]  in_data,
  output logic        frame_rdy,
  output logic [11:0] frame_len,
  output logic        frame_err,
  input  logic        frame_ack,
  input  logic        rd_en,
  input  logic [11:0] rd_addr,
  output logic [7:0]  rd_data,
  output logic [7:0]  drop_cnt,
  output logic        mem_rx_in_en,
  output logic        mem_rx_in_wen,
  output logic [11:0] mem_rx_in_addr,
  output logic [7:0]  mem_rx_in_data,
  input  logic [7:0]  mem_rx_out_data
);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP, S_HOLD} state_t;

  localparam logic [11:0] L_MAX = 12'(MAX_LEN);

  state_t      r_state;
  logic [11:0] r_cnt;
  logic [11:0] r_len;
  logic        r_err;
  logic [7:0]  r_drop;
  logic        r_mem_en;
  logic        r_mem_wen;
  logic [11:0] r_mem_addr;
  logic [7:0]  r_mem_data;
  logic        r_rd_vld;

  state_t      w_nxt;
  logic [11:0] w_cnt_nxt;
  logic [11:0] w_len_nxt;
  logic        w_err_nxt;
  logic        w_drop;
  logic        w_start;
  logic        w_wr;
  logic [11:0] w_wr_addr;
  logic        w_hold_rd;

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    w_len_nxt = r_len;
    w_err_nxt = r_err;
    w_drop    = 1'b0;
    w_start   = 1'b0;
    w_wr      = 1'b0;
    w_wr_addr = '0;
    case (r_state)
      S_IDLE: begin
        if (in_valid && in_sof) w_start = 1'b1;
      end
      S_RECV: begin
        if (in_valid) begin
          if (in_sof) begin
            // new sof aborts the partial frame and restarts at address 0
            w_drop  = 1'b1;
            w_start = 1'b1;
          end else if (r_cnt < L_MAX) begin
            w_wr      = 1'b1;
            w_wr_addr = r_cnt;
            w_cnt_nxt = r_cnt + 12'd1;
            if (in_eof) begin
              w_nxt     = S_HOLD;
              w_len_nxt = r_cnt + 12'd1;
              w_err_nxt = in_err;
            end
          end else begin
            // buffer already full: this byte makes the frame oversize
            w_drop = 1'b1;
            w_nxt  = in_eof ? S_IDLE : S_DROP;
          end
        end
      end
      S_DROP: begin
        if (in_valid && in_sof)      w_start = 1'b1;
        else if (in_valid && in_eof) w_nxt   = S_IDLE;
      end
      S_HOLD: begin
        if (in_valid && in_sof) w_drop = 1'b1;
        if (frame_ack)          w_nxt  = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase

    if (w_start) begin
      w_wr      = 1'b1;
      w_wr_addr = '0;
      w_cnt_nxt = 12'd1;
      if (in_eof) begin
        w_nxt     = S_HOLD;
        w_len_nxt = 12'd1;
        w_err_nxt = in_err;
      end else begin
        w_nxt = S_RECV;
      end
    end
  end

  // The ack cycle already hands the port back to the writer so a read cannot
  // collide with a write from a sof accepted right after IDLE re-entry.
  assign w_hold_rd = (r_state == S_HOLD) && !frame_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_len      <= '0;
      r_err      <= 1'b0;
      r_drop     <= '0;
      r_mem_en   <= 1'b0;
      r_mem_wen  <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_rd_vld   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
      r_err   <= w_err_nxt;
      if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
      if (w_hold_rd) begin
        r_mem_en   <= rd_en;
        r_mem_wen  <= 1'b0;
        r_mem_addr <= rd_addr;
        r_mem_data <= '0;
      end else begin
        r_mem_en   <= w_wr;
        r_mem_wen  <= w_wr;
        r_mem_addr <= w_wr_addr;
        r_mem_data <= w_wr ? in_data : 8'h00;
      end
      // memory data is valid the cycle after a read reaches the memory
      r_rd_vld <= r_mem_en && !r_mem_wen;
    end
  end

  assign frame_rdy       = (r_state == S_HOLD);
  assign frame_len       = r_len;
  assign frame_err       = r_err;
  assign drop_cnt        = r_drop;
  assign mem_rx_in_en    = r_mem_en;
  assign mem_rx_in_wen   = r_mem_wen;
  assign mem_rx_in_addr  = r_mem_addr;
  assign mem_rx_in_data  = r_mem_data;
  assign rd_data         = r_rd_vld ? mem_rx_out_data : 8'h00;

endmodule

// File: tb/tb_uu_acmac_rx_buf_wr.sv
module tb_uu_acmac_rx_buf_wr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_sof, in_eof, in_err;
  logic [7:0]  in_data;
  logic        frame_rdy;
  logic [11:0] frame_len;
  logic        frame_err;
  logic        frame_ack, rd_en;
  logic [11:0] rd_addr;
  logic [7:0]  rd_data, drop_cnt;
  logic        mem_rx_in_en, mem_rx_in_wen;
  logic [11:0] mem_rx_in_addr;
  logic [7:0]  mem_rx_in_data;
  logic [7:0]  mem_rx_out_data = 8'h00;

  always #5 clk = ~clk;

  uu_acmac_rx_buf_wr dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof), .in_err(in_err),
    .in_data(in_data),
    .frame_rdy(frame_rdy), .frame_len(frame_len), .frame_err(frame_err),
    .frame_ack(frame_ack), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .drop_cnt(drop_cnt),
    .mem_rx_in_en(mem_rx_in_en), .mem_rx_in_wen(mem_rx_in_wen),
    .mem_rx_in_addr(mem_rx_in_addr), .mem_rx_in_data(mem_rx_in_data),
    .mem_rx_out_data(mem_rx_out_data)
  );

  // 1536x8 synchronous single-port memory
  logic [7:0] mem [0:1535];
  always @(posedge clk) begin
    if (mem_rx_in_en && (mem_rx_in_addr < 12'd1536)) begin
      if (mem_rx_in_wen) mem[mem_rx_in_addr] <= mem_rx_in_data;
      else               mem_rx_out_data     <= mem[mem_rx_in_addr];
    end
  end

  int n_pass = 0;
  int n_tot  = 0;
  int exp_drop = 0;
  logic [7:0] fb [0:2047];

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask

  function automatic int sat_inc(input int v, input int n);
    return (v + n > 255) ? 255 : v + n;
  endfunction

  task automatic drive(input bit v, input bit s, input bit e, input bit er, input logic [7:0] d);
    @(negedge clk);
    in_valid = v; in_sof = s; in_eof = e; in_err = er; in_data = d;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 8'h00);
  endtask

  task automatic send_frame(input int n, input bit err);
    for (int i = 0; i < n; i++) drive(1, i == 0, i == n - 1, err, fb[i]);
    idle();
  endtask

  task automatic rd_chk(input int a, input int exp, input string name);
    @(negedge clk); rd_en = 1'b1; rd_addr = 12'(a);
    @(negedge clk); rd_en = 1'b0; rd_addr = 12'h000;
    @(negedge clk);
    chk(name, rd_data, exp);
  endtask

  task automatic ack();
    @(negedge clk); frame_ack = 1'b1;
    @(negedge clk); frame_ack = 1'b0;
    chk("rdy_after_ack", frame_rdy, 0);
  endtask

  task automatic chk_held(input int len, input bit err, input string name);
    chk({name, "_rdy"}, frame_rdy, 1);
    chk({name, "_len"}, frame_len, len);
    chk({name, "_err"}, frame_err, err);
    chk({name, "_drop"}, drop_cnt, exp_drop);
  endtask

  typedef struct {
    bit v, s, e, er; logic [7:0] d; bit ack, rde; logic [11:0] rda;
    bit x_en, x_wen; logic [11:0] x_addr; logic [7:0] x_wd;
    bit x_rdy; logic [11:0] x_len; bit x_ferr; logic [7:0] x_drop;
  } vec_t;
  vec_t vec [14];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          v s e er d     ack rde rda   en wen addr   wd     rdy len    ferr drop
    vec[0]  = '{1,1,1,1, 8'hA5, 0,0, 12'd0, 1,1, 12'd0, 8'hA5, 1, 12'd1, 1, 8'd0};
    vec[1]  = '{0,0,0,0, 8'h00, 1,0, 12'd0, 0,0, 12'd0, 8'h00, 0, 12'd0, 0, 8'd0};
    vec[2]  = '{1,1,0,0, 8'h11, 0,0, 12'd0, 1,1, 12'd0, 8'h11, 0, 12'd0, 0, 8'd0};
    vec[3]  = '{1,0,0,0, 8'h22, 0,0, 12'd0, 1,1, 12'd1, 8'h22, 0, 12'd0, 0, 8'd0};
    vec[4]  = '{1,0,1,0, 8'h33, 0,0, 12'd0, 1,1, 12'd2, 8'h33, 1, 12'd3, 0, 8'd0};
    vec[5]  = '{0,0,0,0, 8'h00, 0,1, 12'd1, 1,0, 12'd1, 8'h00, 1, 12'd3, 0, 8'd0};
    vec[6]  = '{1,1,0,0, 8'h44, 0,0, 12'd0, 0,0, 12'd0, 8'h00, 1, 12'd3, 0, 8'd1};
    vec[7]  = '{1,1,0,0, 8'h45, 1,0, 12'd0, 0,0, 12'd0, 8'h00, 0, 12'd0, 0, 8'd2};
    vec[8]  = '{1,1,0,0, 8'h55, 0,0, 12'd0, 1,1, 12'd0, 8'h55, 0, 12'd0, 0, 8'd2};
    vec[9]  = '{1,0,0,0, 8'h66, 0,0, 12'd0, 1,1, 12'd1, 8'h66, 0, 12'd0, 0, 8'd2};
    vec[10] = '{1,1,0,0, 8'h77, 0,0, 12'd0, 1,1, 12'd0, 8'h77, 0, 12'd0, 0, 8'd3};
    vec[11] = '{1,0,1,1, 8'h88, 0,0, 12'd0, 1,1, 12'd1, 8'h88, 1, 12'd2, 1, 8'd3};
    vec[12] = '{0,0,0,0, 8'h00, 1,0, 12'd0, 0,0, 12'd0, 8'h00, 0, 12'd0, 0, 8'd3};
    vec[13] = '{1,0,0,0, 8'h99, 0,0, 12'd0, 0,0, 12'd0, 8'h00, 0, 12'd0, 0, 8'd3};

    rst_n = 1'b0; in_valid = 0; in_sof = 0; in_eof = 0; in_err = 0; in_data = 0;
    frame_ack = 0; rd_en = 0; rd_addr = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", mem_rx_in_en, 0);   chk("rst_wen", mem_rx_in_wen, 0);
    chk("rst_addr", mem_rx_in_addr, 0); chk("rst_wdata", mem_rx_in_data, 0);
    chk("rst_rdy", frame_rdy, 0);     chk("rst_len", frame_len, 0);
    chk("rst_ferr", frame_err, 0);    chk("rst_drop", drop_cnt, 0);
    chk("rst_rdata", rd_data, 0);
    @(negedge clk); rst_n = 1'b1;

    // cycle-accurate table
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      in_valid = vec[i].v; in_sof = vec[i].s; in_eof = vec[i].e; in_err = vec[i].er;
      in_data = vec[i].d; frame_ack = vec[i].ack; rd_en = vec[i].rde; rd_addr = vec[i].rda;
      @(posedge clk); #1;
      chk($sformatf("v%0d_en", i), mem_rx_in_en, vec[i].x_en);
      chk($sformatf("v%0d_rdy", i), frame_rdy, vec[i].x_rdy);
      chk($sformatf("v%0d_drop", i), drop_cnt, vec[i].x_drop);
      if (vec[i].x_en) begin
        chk($sformatf("v%0d_wen", i), mem_rx_in_wen, vec[i].x_wen);
        chk($sformatf("v%0d_addr", i), mem_rx_in_addr, vec[i].x_addr);
        if (vec[i].x_wen) chk($sformatf("v%0d_wd", i), mem_rx_in_data, vec[i].x_wd);
      end
      if (vec[i].x_rdy) begin
        chk($sformatf("v%0d_len", i), frame_len, vec[i].x_len);
        chk($sformatf("v%0d_ferr", i), frame_err, vec[i].x_ferr);
      end
    end
    @(negedge clk);
    in_valid = 0; in_sof = 0; in_eof = 0; frame_ack = 0; rd_en = 0; rd_addr = 0;
    exp_drop = 3;

    // 64-byte ramp frame with full readback
    for (int i = 0; i < 64; i++) fb[i] = 8'(i);
    send_frame(64, 0);
    chk_held(64, 0, "f64");
    for (int i = 0; i < 64; i++) rd_chk(i, fb[i], $sformatf("f64_rd%0d", i));
    ack();

    // 1-byte frame with error
    fb[0] = 8'hA5;
    send_frame(1, 1);
    chk_held(1, 1, "f1");
    rd_chk(0, 8'hA5, "f1_rd0");
    ack();

    // full-size frame, then one byte over
    for (int i = 0; i < 1537; i++) fb[i] = 8'($urandom);
    send_frame(1536, 0);
    chk_held(1536, 0, "f1536");
    rd_chk(0, fb[0], "f1536_rd0");
    rd_chk(767, fb[767], "f1536_rd767");
    rd_chk(1535, fb[1535], "f1536_rd1535");
    ack();
    send_frame(1537, 0);
    exp_drop = sat_inc(exp_drop, 1);
    chk("f1537_rdy", frame_rdy, 0);
    chk("f1537_drop", drop_cnt, exp_drop);
    fb[0] = 8'h5A; fb[1] = 8'hC3;
    send_frame(2, 0);
    chk_held(2, 0, "after1537");
    rd_chk(1, 8'hC3, "after1537_rd1");
    ack();

    // three frames arrive while a frame is held
    for (int i = 0; i < 16; i++) fb[i] = 8'($urandom);
    send_frame(16, 1);
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 5; i++) drive(1, i == 0, i == 4, 0, 8'($urandom));
    idle();
    exp_drop = sat_inc(exp_drop, 3);
    chk_held(16, 1, "held3");
    for (int i = 0; i < 16; i++) rd_chk(i, fb[i], $sformatf("held3_rd%0d", i));
    ack();
    for (int i = 0; i < 8; i++) fb[i] = 8'($urandom);
    send_frame(8, 0);
    chk_held(8, 0, "post_ack");
    rd_chk(7, fb[7], "post_ack_rd7");
    ack();

    // sof mid-frame at byte 10, then a 20-byte frame
    for (int i = 0; i < 10; i++) drive(1, i == 0, 0, 0, 8'hEE);
    for (int i = 0; i < 20; i++) fb[i] = 8'($urandom);
    send_frame(20, 0);
    exp_drop = sat_inc(exp_drop, 1);
    chk_held(20, 0, "midsof");
    rd_chk(0, fb[0], "midsof_rd0");
    rd_chk(19, fb[19], "midsof_rd19");
    ack();

    // asynchronous reset in the middle of a frame
    for (int i = 0; i < 5; i++) drive(1, i == 0, 0, 0, 8'h3C);
    #2; rst_n = 1'b0; in_valid = 0; in_sof = 0;
    #1;
    chk("arst_en", mem_rx_in_en, 0);   chk("arst_wen", mem_rx_in_wen, 0);
    chk("arst_addr", mem_rx_in_addr, 0); chk("arst_wdata", mem_rx_in_data, 0);
    chk("arst_rdy", frame_rdy, 0);     chk("arst_len", frame_len, 0);
    chk("arst_ferr", frame_err, 0);    chk("arst_drop", drop_cnt, 0);
    @(negedge clk); rst_n = 1'b1;
    exp_drop = 0;

    // randomized frames against a frame-level reference
    for (int f = 0; f < 30; f++) begin
      int n, g;
      bit er;
      n  = (f == 9 || f == 21) ? 1537 + $urandom_range(0, 3) : $urandom_range(1, 60);
      er = 1'($urandom);
      g  = $urandom_range(0, 3);
      for (int i = 0; i < g; i++) drive(1, 0, 1'($urandom), 0, 8'($urandom));
      idle();
      for (int i = 0; i < n; i++) fb[i] = 8'($urandom);
      send_frame(n, er);
      if (n > 1536) begin
        exp_drop = sat_inc(exp_drop, 1);
        chk($sformatf("r%0d_rdy", f), frame_rdy, 0);
        chk($sformatf("r%0d_drop", f), drop_cnt, exp_drop);
      end else begin
        int k;
        chk_held(n, er, $sformatf("r%0d", f));
        for (int j = 0; j < 3; j++) begin
          int a;
          a = $urandom_range(0, n - 1);
          rd_chk(a, fb[a], $sformatf("r%0d_rd%0d", f, a));
        end
        rd_chk(n - 1, fb[n - 1], $sformatf("r%0d_rdlast", f));
        k = $urandom_range(0, 2);
        for (int j = 0; j < k; j++) drive(1, 1, 1, 0, 8'($urandom));
        idle();
        exp_drop = sat_inc(exp_drop, k);
        chk($sformatf("r%0d_hdrop", f), drop_cnt, exp_drop);
        ack();
      end
    end

    // drop counter saturation
    fb[0] = 8'h42;
    send_frame(1, 0);
    for (int i = 0; i < 300; i++) drive(1, 1, 0, 0, 8'h00);
    idle();
    exp_drop = sat_inc(exp_drop, 300);
    chk("sat_drop", drop_cnt, 255);
    chk("sat_model", drop_cnt, exp_drop);
    rd_chk(0, 8'h42, "sat_rd0");
    ack();
    chk("sat_rd_idle", rd_data, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
